// File: rtl/enemy_path_square.sv
`default_nettype none
// ============================================================================
// Module   : enemy_path_square
// Purpose  : Walks one enemy along a three-segment path, one step per frame,
//            and runs the registered per-pixel rectangle hit test.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_path_square #(
    parameter int unsigned OBJECT_WIDTH  = 32,
    parameter int unsigned OBJECT_HEIGHT = 32,
    parameter int unsigned START_X       = 0,
    parameter int unsigned START_Y       = 96,
    parameter int unsigned TURN_X        = 320,
    parameter int unsigned TURN_Y        = 320,
    parameter int unsigned END_X         = 608,
    parameter int unsigned SPEED         = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        spawn,
    input  logic        hit,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        alive,
    output logic        reachedEnd,
    output logic        killed
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEG1 = 2'd1;
    localparam logic [1:0] S_SEG2 = 2'd2;
    localparam logic [1:0] S_SEG3 = 2'd3;

    localparam logic [10:0] c_start_x = 11'(START_X);
    localparam logic [10:0] c_start_y = 11'(START_Y);
    localparam logic [11:0] c_turn_x  = 12'(TURN_X);
    localparam logic [11:0] c_turn_y  = 12'(TURN_Y);
    localparam logic [11:0] c_end_x   = 12'(END_X);
    localparam logic [11:0] c_speed   = 12'(SPEED);
    localparam logic [11:0] c_width   = 12'(OBJECT_WIDTH);
    localparam logic [11:0] c_height  = 12'(OBJECT_HEIGHT);

    logic [1:0]  state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        reached_q, reached_d;
    logic        killed_q, killed_d;
    logic        inside_q, inside_d;
    logic [10:0] offx_q, offx_d;
    logic [10:0] offy_q, offy_d;

    logic [11:0] w_step_x;
    logic [11:0] w_step_y;
    logic [11:0] w_right;
    logic [11:0] w_bottom;
    logic        w_alive;

    // 12-bit sums keep the clamp compare and rectangle bounds from wrapping
    assign w_step_x = {1'b0, x_q} + c_speed;
    assign w_step_y = {1'b0, y_q} + c_speed;
    assign w_right  = {1'b0, x_q} + c_width;
    assign w_bottom = {1'b0, y_q} + c_height;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= c_start_x;
            y_q       <= c_start_y;
            reached_q <= 1'b0;
            killed_q  <= 1'b0;
            inside_q  <= 1'b0;
            offx_q    <= 11'd0;
            offy_q    <= 11'd0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            reached_q <= reached_d;
            killed_q  <= killed_d;
            inside_q  <= inside_d;
            offx_q    <= offx_d;
            offy_q    <= offy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        reached_d = 1'b0;
        killed_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (spawn) begin
                    state_d = S_SEG1;
                    x_d     = c_start_x;
                    y_d     = c_start_y;
                end
            end
            S_SEG1: begin
                if (hit) begin
                    state_d  = S_IDLE;
                    killed_d = 1'b1;
                end else if (startOfFrame) begin
                    if (w_step_x >= c_turn_x) begin
                        x_d     = c_turn_x[10:0];
                        state_d = S_SEG2;
                    end else begin
                        x_d = w_step_x[10:0];
                    end
                end
            end
            S_SEG2: begin
                if (hit) begin
                    state_d  = S_IDLE;
                    killed_d = 1'b1;
                end else if (startOfFrame) begin
                    if (w_step_y >= c_turn_y) begin
                        y_d     = c_turn_y[10:0];
                        state_d = S_SEG3;
                    end else begin
                        y_d = w_step_y[10:0];
                    end
                end
            end
            S_SEG3: begin
                if (hit) begin
                    state_d  = S_IDLE;
                    killed_d = 1'b1;
                end else if (startOfFrame) begin
                    if (w_step_x >= c_end_x) begin
                        x_d       = c_end_x[10:0];
                        state_d   = S_IDLE;
                        reached_d = 1'b1;
                    end else begin
                        x_d = w_step_x[10:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Hit test uses the position and liveness registered before this edge
    always_comb begin
        w_alive  = (state_q != S_IDLE);
        inside_d = w_alive &&
                   (pixelX >= x_q) && ({1'b0, pixelX} < w_right) &&
                   (pixelY >= y_q) && ({1'b0, pixelY} < w_bottom);
        offx_d   = inside_d ? (pixelX - x_q) : 11'd0;
        offy_d   = inside_d ? (pixelY - y_q) : 11'd0;
    end

    assign alive           = w_alive;
    assign topLeftX        = x_q;
    assign topLeftY        = y_q;
    assign reachedEnd      = reached_q;
    assign killed          = killed_q;
    assign InsideRectangle = inside_q;
    assign offsetX         = offx_q;
    assign offsetY         = offy_q;

endmodule
`default_nettype wire
